mem_arbiter: RTL and testbench



---
 rtl/mem_pkg.sv | 18 +
 rtl/arb_rr2.sv | 21 ++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, grant owner
// and the default watchdog limit.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_t;

    localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker; on a tie the port not served last wins.
module arb_rr2
    import mem_pkg::*;
(
    input  logic req_if,
    input  logic req_dm,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant       = GNT_IF;
        grant_valid = req_if | req_dm;
        if (req_if && req_dm)
            grant = (last_grant == GNT_IF) ? GNT_DM : GNT_IF;
        else if (req_dm)
            grant = GNT_DM;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory between instruction fetch and data
// access, one transaction at a time, with a per-transaction watchdog.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDRESS_WIDTH-1:0]  if_addr,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    output logic                      if_valid,
    output logic                      if_stall,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [ADDRESS_WIDTH-1:0]  dm_addr,
    input  logic [DATA_WIDTH-1:0]     dm_wdata,
    input  logic [DATA_WIDTH/8-1:0]   dm_be,
    output logic [DATA_WIDTH-1:0]     dm_rdata,
    output logic                      dm_valid,
    output logic                      dm_stall,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_ack,
    output logic                      bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t                     r_state;
    gnt_t                       r_owner;
    logic [CW-1:0]              r_cnt;
    logic                       r_mem_req;
    logic                       r_mem_we;
    logic [ADDRESS_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]      r_mem_wdata;
    logic [DATA_WIDTH/8-1:0]    r_mem_be;
    logic [DATA_WIDTH-1:0]      r_if_rdata;
    logic [DATA_WIDTH-1:0]      r_dm_rdata;
    logic                       r_if_valid;
    logic                       r_dm_valid;
    logic                       r_bus_err;
    logic                       w_grant;
    logic                       w_grant_valid;

    arb_rr2 u_arb (
        .req_if      (if_req),
        .req_dm      (dm_req),
        .last_grant  (r_owner),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    // r_owner doubles as the round-robin history: it always names the last port granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= GNT_IF;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner   <= gnt_t'(w_grant);
                        r_mem_req <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_BUSY;
                        if (w_grant == GNT_DM) begin
                            r_mem_we    <= dm_we;
                            r_mem_addr  <= dm_addr;
                            r_mem_wdata <= dm_wdata;
                            r_mem_be    <= dm_be;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= if_addr;
                            r_mem_wdata <= '0;
                            r_mem_be    <= '1;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_RESP;
                        if (r_owner == GNT_IF) begin
                            r_if_rdata <= mem_rdata;
                            r_if_valid <= 1'b1;
                        end else begin
                            if (!r_mem_we)
                                r_dm_rdata <= mem_rdata;
                            r_dm_valid <= 1'b1;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        // Watchdog expiry: complete with zero data and flag the bus.
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= S_RESP;
                        if (r_owner == GNT_IF) begin
                            r_if_rdata <= '0;
                            r_if_valid <= 1'b1;
                        end else begin
                            r_dm_rdata <= '0;
                            r_dm_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_if_valid <= 1'b0;
                    r_dm_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_stall  = ~rst & if_req & ~r_if_valid;
    assign dm_stall  = ~rst & dm_req & ~r_dm_valid;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_valid  = r_dm_valid;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: completions are checked against a
// scoreboard of expected (port, rdata) pairs pushed as requests are driven.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        dm_valid, dm_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack, bus_err;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_dm  = 32'h0;

    mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every valid pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (if_valid || dm_valid) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed if_valid=%b dm_valid=%b expected no completion",
                       if_valid, dm_valid);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_one_valid", {31'b0, if_valid & dm_valid}, 32'h0);
                chk("sb_port", {31'b0, dm_valid}, {31'b0, e.port});
                chk("sb_rdata", dm_valid ? dm_rdata : if_rdata, e.data);
            end
        end
    end

    // Single zero-wait read on one port, ending back in IDLE.
    task automatic rd(input logic port, input logic [31:0] addr, input logic [31:0] data);
        if (port) begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = addr; end
        else begin if_req = 1'b1; if_addr = addr; end
        sb.push_back('{port, data});
        tick;
        chk("rd_mem_req", {31'b0, mem_req}, 32'h1);
        chk("rd_mem_addr", mem_addr, addr);
        chk("rd_mem_we", {31'b0, mem_we}, 32'h0);
        mem_ack = 1'b1; mem_rdata = data;
        tick;
        mem_ack = 1'b0;
        chk("rd_valid", {31'b0, port ? dm_valid : if_valid}, 32'h1);
        if (port) begin dm_req = 1'b0; exp_dm = data; end
        else if_req = 1'b0;
        tick;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'hF;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tick; tick;
        chk("rst_if_stall", {31'b0, if_stall}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
        if_req = 1'b0; rst = 1'b0;
        tick;

        // First tie after reset goes to DM, then IF from the next IDLE.
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        sb.push_back('{1'b1, 32'h11112222});
        sb.push_back('{1'b0, 32'hAAAA0001});
        tick;
        chk("tie1_mem_req", {31'b0, mem_req}, 32'h1);
        chk("tie1_addr_dm", mem_addr, 32'h2000);
        chk("tie1_if_stall", {31'b0, if_stall}, 32'h1);
        chk("tie1_dm_stall", {31'b0, dm_stall}, 32'h1);
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick;
        mem_ack = 1'b0;
        chk("tie1_dm_valid", {31'b0, dm_valid}, 32'h1);
        chk("tie1_dm_stall_lo", {31'b0, dm_stall}, 32'h0);
        chk("tie1_if_stall_hold", {31'b0, if_stall}, 32'h1);
        dm_req = 1'b0; exp_dm = 32'h11112222;
        tick;
        chk("tie1_idle_no_req", {31'b0, mem_req}, 32'h0);
        tick;
        chk("tie1_if_granted", {31'b0, mem_req}, 32'h1);
        chk("tie1_addr_if", mem_addr, 32'h200);
        chk("tie1_be_if", {28'b0, mem_be}, 32'hF);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA0001;
        tick;
        mem_ack = 1'b0;
        chk("tie1_if_valid", {31'b0, if_valid}, 32'h1);
        if_req = 1'b0;
        tick;

        // Zero-wait fetch, then a DM read so the next tie belongs to IF.
        rd(1'b0, 32'h100, 32'h00500093);
        chk("t1_if_valid_lo", {31'b0, if_valid}, 32'h0);
        rd(1'b1, 32'h2008, 32'h0BADF00D);

        if_req = 1'b1; if_addr = 32'h208;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200C;
        sb.push_back('{1'b0, 32'h00000111});
        sb.push_back('{1'b1, 32'h0D0D0D0D});
        tick;
        chk("tie2_addr_if", mem_addr, 32'h208);
        mem_ack = 1'b1; mem_rdata = 32'h00000111;
        tick;
        mem_ack = 1'b0; if_req = 1'b0;
        tick; tick;
        chk("tie2_addr_dm", mem_addr, 32'h200C);
        mem_ack = 1'b1; mem_rdata = 32'h0D0D0D0D;
        tick;
        mem_ack = 1'b0; dm_req = 1'b0; exp_dm = 32'h0D0D0D0D;
        tick;

        // Write with three wait cycles: fields held four cycles, dm_rdata untouched.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF;
        sb.push_back('{1'b1, exp_dm});
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("wr_mem_req", {31'b0, mem_req}, 32'h1);
            chk("wr_mem_we", {31'b0, mem_we}, 32'h1);
            chk("wr_mem_addr", mem_addr, 32'h2004);
            chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
            if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'h55555555; end
        end
        tick;
        mem_ack = 1'b0;
        chk("wr_dm_valid", {31'b0, dm_valid}, 32'h1);
        chk("wr_mem_req_lo", {31'b0, mem_req}, 32'h0);
        dm_req = 1'b0; dm_we = 1'b0;
        tick;

        // Watchdog: four cycles of mem_req, then zero data and sticky bus_err.
        if_req = 1'b1; if_addr = 32'h300;
        sb.push_back('{1'b0, 32'h0});
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("to_mem_req", {31'b0, mem_req}, 32'h1);
            chk("to_bus_err_lo", {31'b0, bus_err}, 32'h0);
        end
        tick;
        chk("to_mem_req_lo", {31'b0, mem_req}, 32'h0);
        chk("to_if_valid", {31'b0, if_valid}, 32'h1);
        chk("to_bus_err", {31'b0, bus_err}, 32'h1);
        if_req = 1'b0;
        tick;
        rd(1'b1, 32'h2010, 32'h12345678);
        chk("to_bus_err_sticky", {31'b0, bus_err}, 32'h1);

        // Reset during BUSY; a late ack must be ignored.
        if_req = 1'b1; if_addr = 32'h400;
        tick;
        chk("rb_busy", {31'b0, mem_req}, 32'h1);
        rst = 1'b1; if_req = 1'b0;
        tick;
        chk("rb_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rb_bus_err", {31'b0, bus_err}, 32'h0);
        chk("rb_dm_rdata", dm_rdata, 32'h0);
        chk("rb_mem_addr", mem_addr, 32'h0);
        rst = 1'b0; exp_dm = 32'h0;
        tick;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick;
        mem_ack = 1'b0;
        chk("rb_no_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rb_mem_req_lo", {31'b0, mem_req}, 32'h0);
        chk("rb_if_rdata", if_rdata, 32'h0);
        tick;

        // if_req held across completion: no regrant from RESP.
        if_req = 1'b1; if_addr = 32'h100;
        sb.push_back('{1'b0, 32'h00000013});
        tick;
        chk("rg_addr0", mem_addr, 32'h100);
        mem_ack = 1'b1; mem_rdata = 32'h00000013;
        tick;
        mem_ack = 1'b0;
        chk("rg_if_valid", {31'b0, if_valid}, 32'h1);
        if_addr = 32'h104;
        sb.push_back('{1'b0, 32'h00100093});
        tick;
        chk("rg_no_regrant", {31'b0, mem_req}, 32'h0);
        tick;
        chk("rg_mem_req", {31'b0, mem_req}, 32'h1);
        chk("rg_addr1", mem_addr, 32'h104);
        mem_ack = 1'b1; mem_rdata = 32'h00100093;
        tick;
        mem_ack = 1'b0; if_req = 1'b0;
        tick; tick;

        chk("sb_drained", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
